// File: rtl/spi_flash_ctrl.sv
// SPI flash controller: a small CPU register window with asynchronous strobes
// driving a mode-0, MSB-first byte shifter with a programmable SCK divider.
module spi_flash_ctrl #(
    parameter logic [7:0] DIV_RST = 8'h18
) (
    input  logic       clk_i,
    input  logic       mcu_rst_i,
    input  logic       mcu_cs_i,
    input  logic       mcu_wr_i,
    input  logic       mcu_rd_i,
    input  logic [7:0] mcu_addr_i8,
    input  logic [7:0] mcu_wrdat_i8,
    output logic [7:0] mcu_rddat_o8,
    output logic       mcu_int_o,
    output logic       spi_ncs_o,
    output logic       spi_clk_o,
    output logic       spi_mosi_o,
    input  logic       spi_miso_i
);

    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_DIV    = 4'h1;
    localparam logic [3:0] ADDR_TX     = 4'h2;
    localparam logic [3:0] ADDR_RX     = 4'h3;
    localparam logic [3:0] ADDR_STATUS = 4'h4;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t     state, state_next;

    logic       wr_s1, wr_s2, wr_d;
    logic       rd_s1, rd_s2, rd_d, rd_is_rx;
    logic [1:0] sync_vld;
    logic       wr_commit, rd_fall;

    logic [3:0] addr;
    logic       addr_unused;

    logic       ctrl_ncs, int_en;
    logic [7:0] div, rx_data, shift, phase_cnt;
    logic [2:0] bit_cnt;
    logic       done, ovr, busy, sck, mosi, int_q;
    logic       phase_end, tx_start, wr_tx, wr_status, done_clr;

    assign addr        = mcu_addr_i8[3:0];
    assign addr_unused = ^mcu_addr_i8[7:4];

    // Strobe synchronizers. The write edge detector reads as "already high"
    // until the pipeline holds a post-reset sample, so a strobe held across
    // reset release never looks like a fresh edge.
    always_ff @(posedge clk_i) begin
        if (mcu_rst_i) begin
            wr_s1    <= 1'b0;
            wr_s2    <= 1'b0;
            wr_d     <= 1'b1;
            rd_s1    <= 1'b0;
            rd_s2    <= 1'b0;
            rd_d     <= 1'b0;
            rd_is_rx <= 1'b0;
            sync_vld <= 2'b00;
        end else begin
            wr_s1    <= mcu_cs_i & mcu_wr_i;
            wr_s2    <= wr_s1;
            sync_vld <= {sync_vld[0], 1'b1};
            wr_d     <= sync_vld[1] ? wr_s2 : 1'b1;
            rd_s1    <= mcu_cs_i & mcu_rd_i;
            rd_s2    <= rd_s1;
            rd_d     <= rd_s2;
            if (rd_s2)
                rd_is_rx <= (addr == ADDR_RX);
        end
    end

    assign wr_commit = wr_s2 & ~wr_d;
    assign rd_fall   = rd_d & ~rd_s2;

    assign busy      = (state != IDLE);
    assign phase_end = (phase_cnt == div);
    assign wr_tx     = wr_commit && (addr == ADDR_TX);
    assign wr_status = wr_commit && (addr == ADDR_STATUS);
    assign tx_start  = wr_tx && !busy;
    assign done_clr  = (wr_status && mcu_wrdat_i8[1]) || (rd_fall && rd_is_rx);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent behaviour.
    always_ff @(posedge clk_i) begin
        if (mcu_rst_i)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: next-state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tx_start) state_next = LOW;
            LOW:     if (phase_end) state_next = HIGH;
            HIGH:    if (phase_end) state_next = (bit_cnt == 3'd7) ? DONE : LOW;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (mcu_rst_i) begin
            ctrl_ncs  <= 1'b1;
            int_en    <= 1'b0;
            div       <= DIV_RST;
            rx_data   <= 8'h00;
            shift     <= 8'h00;
            phase_cnt <= 8'h00;
            bit_cnt   <= 3'd0;
            done      <= 1'b0;
            ovr       <= 1'b0;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            int_q     <= 1'b0;
        end else begin
            if (wr_commit && (addr == ADDR_CTRL)) begin
                ctrl_ncs <= mcu_wrdat_i8[0];
                int_en   <= mcu_wrdat_i8[1];
            end
            if (wr_commit && (addr == ADDR_DIV) && !busy)
                div <= mcu_wrdat_i8;

            if (state_next != state)
                phase_cnt <= 8'h00;
            else if (busy)
                phase_cnt <= phase_cnt + 8'd1;

            if (tx_start) begin
                shift   <= mcu_wrdat_i8;
                mosi    <= mcu_wrdat_i8[7];
                bit_cnt <= 3'd0;
            end
            if ((state == LOW) && phase_end) begin
                shift <= {shift[6:0], spi_miso_i};
                sck   <= 1'b1;
            end
            // The last bit stays on MOSI; after the final shift, shift[7] is receive data.
            if ((state == HIGH) && phase_end) begin
                sck     <= 1'b0;
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt != 3'd7)
                    mosi <= shift[7];
            end
            if (state == DONE)
                rx_data <= shift;

            // Completion outranks any clear landing on the same edge.
            if (state == DONE)
                done <= 1'b1;
            else if (tx_start || done_clr)
                done <= 1'b0;

            if (wr_tx && busy)
                ovr <= 1'b1;
            else if (wr_status && mcu_wrdat_i8[2])
                ovr <= 1'b0;

            int_q <= done & int_en;
        end
    end

    always_comb begin
        mcu_rddat_o8 = 8'h00;
        if (mcu_cs_i && mcu_rd_i) begin
            case (addr)
                ADDR_CTRL:   mcu_rddat_o8 = {6'b0, int_en, ctrl_ncs};
                ADDR_DIV:    mcu_rddat_o8 = div;
                ADDR_RX:     mcu_rddat_o8 = rx_data;
                ADDR_STATUS: mcu_rddat_o8 = {5'b0, ovr, done, busy};
                default:     mcu_rddat_o8 = 8'h00;
            endcase
        end
    end

    assign spi_ncs_o  = ctrl_ncs;
    assign spi_clk_o  = sck;
    assign spi_mosi_o = mosi;
    assign mcu_int_o  = int_q;

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Self-checking bench for spi_flash_ctrl: expected MOSI bytes and SCK phase
// lengths are queued per transfer and checked by a bus monitor as bytes appear.
module tb_spi_flash_ctrl;

    logic       clk, rst, cs, wr, rd, miso, miso_loop, miso_val;
    logic [7:0] addr, wrdat, rddat;
    logic       irq, ncs, sck, mosi;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] data;
        int         half;
    } exp_t;

    exp_t exp_q[$];

    spi_flash_ctrl #(.DIV_RST(8'h18)) dut (
        .clk_i        (clk),
        .mcu_rst_i    (rst),
        .mcu_cs_i     (cs),
        .mcu_wr_i     (wr),
        .mcu_rd_i     (rd),
        .mcu_addr_i8  (addr),
        .mcu_wrdat_i8 (wrdat),
        .mcu_rddat_o8 (rddat),
        .mcu_int_o    (irq),
        .spi_ncs_o    (ncs),
        .spi_clk_o    (sck),
        .spi_mosi_o   (mosi),
        .spi_miso_i   (miso)
    );

    assign miso = miso_loop ? mosi : miso_val;

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Commit happens on the third rising edge after the strobe is raised.
    task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; wrdat = d; cs = 1'b1; wr = 1'b1;
        repeat (4) @(negedge clk);
        cs = 1'b0; wr = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic read_reg(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a; cs = 1'b1; rd = 1'b1;
        #1 d = rddat;
        repeat (4) @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        #1 check("rddat_idle", rddat, 8'h00);
        repeat (5) @(negedge clk);
    endtask

    // Starts a transfer, then polls STATUS.busy live and counts the cycles it is high.
    task automatic xfer_polled(input logic [7:0] tx, input int half, input int exp_cycles);
        int cycles;
        exp_q.push_back(exp_t'{tx, half});
        @(negedge clk);
        addr = 8'h02; wrdat = tx; cs = 1'b1; wr = 1'b1;
        repeat (3) @(negedge clk);
        wr = 1'b0; addr = 8'h04; rd = 1'b1;
        #1 cycles = 0;
        while (rddat[0] && cycles < 2000) begin
            cycles++;
            @(negedge clk);
            #1;
        end
        check("busy_cycles", cycles, exp_cycles);
        cs = 1'b0; rd = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // SPI monitor: assembles MOSI at each SCK rise, checks phase lengths, pops expectations.
    int         mon_bits = 0;
    logic [7:0] mon_byte = 8'h00;
    int         high_len = 0;
    int         low_len  = 0;
    logic       sck_prev = 1'b0;

    always @(negedge clk) begin
        #1;
        if (rst) begin
            mon_bits = 0;
            high_len = 0;
            low_len  = 0;
            sck_prev = 1'b0;
        end else begin
            if (sck && !sck_prev) begin
                if (mon_bits != 0 && exp_q.size() > 0)
                    check("sck_low_len", low_len, exp_q[0].half);
                mon_byte = {mon_byte[6:0], mosi};
                mon_bits++;
                high_len = 1;
            end else if (sck) begin
                high_len++;
            end else if (sck_prev) begin
                if (exp_q.size() > 0)
                    check("sck_high_len", high_len, exp_q[0].half);
                low_len = 1;
                if (mon_bits == 8) begin
                    logic have;
                    exp_t e;
                    e    = exp_t'{8'h00, 0};
                    have = (exp_q.size() > 0);
                    if (have)
                        e = exp_q.pop_front();
                    check("sb_has_expect", have, 1'b1);
                    if (have)
                        check("mosi_byte", mon_byte, e.data);
                    mon_bits = 0;
                end
            end else begin
                low_len++;
            end
            sck_prev = sck;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        int rises, cyc;
        logic prev;

        rst = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0;
        addr = 8'h00; wrdat = 8'h00; miso_loop = 1'b0; miso_val = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Reset state
        #1;
        check("rst_ncs", ncs, 1'b1);
        check("rst_sck", sck, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_int", irq, 1'b0);
        read_reg(8'h00, d); check("rst_ctrl", d, 8'h01);
        read_reg(8'h01, d); check("rst_div", d, 8'h18);
        read_reg(8'h03, d); check("rst_rx", d, 8'h00);
        read_reg(8'h04, d); check("rst_status", d, 8'h00);

        // Decode holes and write-only TXDATA
        for (int off = 5; off < 16; off++) begin
            write_reg(8'(off), 8'hFF);
            read_reg(8'(off), d);
            check($sformatf("decode_rd_%0h", off), d, 8'h00);
        end
        write_reg(8'h02, 8'h00); // nothing to start? it is idle, so this starts a transfer
        exp_q.push_back(exp_t'{8'h00, 25});
        repeat (420) @(negedge clk);
        read_reg(8'h02, d); check("tx_reads_zero", d, 8'h00);
        #1;
        check("decode_ncs", ncs, 1'b1);
        check("decode_int", irq, 1'b0);
        read_reg(8'h00, d); check("decode_ctrl", d, 8'h01);
        read_reg(8'h01, d); check("decode_div", d, 8'h18);
        write_reg(8'h04, 8'h02);

        // Loopback at DIV=0
        write_reg(8'h01, 8'h00);
        write_reg(8'h00, 8'h00);
        miso_loop = 1'b1;
        xfer_polled(8'hA5, 1, 17);
        read_reg(8'h04, d); check("lb_status_done", d, 8'h02);
        read_reg(8'h03, d); check("lb_rx", d, 8'hA5);
        read_reg(8'h04, d); check("lb_status_clr", d, 8'h00);

        // Default divider, MISO held high
        write_reg(8'h01, 8'h18);
        miso_loop = 1'b0; miso_val = 1'b1;
        xfer_polled(8'h00, 25, 401);
        read_reg(8'h03, d); check("div_rx", d, 8'hFF);

        // Overrun, DIV write while busy, CTRL write mid-transfer
        write_reg(8'h01, 8'h03);
        miso_loop = 1'b1;
        exp_q.push_back(exp_t'{8'h3C, 4});
        write_reg(8'h02, 8'h3C);
        write_reg(8'h02, 8'hFF);
        write_reg(8'h01, 8'h00);
        write_reg(8'h00, 8'h01);
        #1 check("ncs_midxfer_hi", ncs, 1'b1);
        write_reg(8'h00, 8'h00);
        #1 check("ncs_midxfer_lo", ncs, 1'b0);
        repeat (40) @(negedge clk);
        read_reg(8'h04, d); check("ovr_status", d, 8'h06);
        read_reg(8'h01, d); check("ovr_div_kept", d, 8'h03);
        read_reg(8'h03, d); check("ovr_rx", d, 8'h3C);
        write_reg(8'h04, 8'h04);
        read_reg(8'h04, d); check("ovr_cleared", d, 8'h00);

        // Interrupt set, cleared by RXDATA read, then set winning over a coincident clear
        write_reg(8'h01, 8'h00);
        write_reg(8'h00, 8'h02);
        xfer_polled(8'h5A, 1, 17);
        repeat (2) @(negedge clk);
        #1 check("int_set", irq, 1'b1);
        read_reg(8'h03, d); check("int_rx", d, 8'h5A);
        #1 check("int_cleared", irq, 1'b0);

        // Commit lands on edge P3, DONE ends on P3+17=P20; the read released
        // after P17 is seen falling on P20 as well.
        exp_q.push_back(exp_t'{8'hC3, 1});
        @(negedge clk);
        addr = 8'h02; wrdat = 8'hC3; cs = 1'b1; wr = 1'b1;
        repeat (3) @(negedge clk);
        cs = 1'b0; wr = 1'b0;
        repeat (3) @(negedge clk);
        addr = 8'h03; cs = 1'b1; rd = 1'b1;
        repeat (11) @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        repeat (5) @(negedge clk);
        #1 check("int_set_wins", irq, 1'b1);
        read_reg(8'h04, d); check("int_status_done", d, 8'h02);
        write_reg(8'h04, 8'h02);
        #1 check("int_status_clr", irq, 1'b0);
        read_reg(8'h03, d); check("int_rx2", d, 8'hC3);
        read_reg(8'h04, d); check("int_status_zero", d, 8'h00);

        // Reset during the 4th HIGH phase with a DIV write strobe held across release
        write_reg(8'h00, 8'h00);
        write_reg(8'h01, 8'h07);
        write_reg(8'h02, 8'hF0);
        rises = 0; prev = sck; cyc = 0;
        while (rises < 4 && cyc < 1000) begin
            @(negedge clk);
            #1;
            if (sck && !prev) rises++;
            prev = sck;
            cyc++;
        end
        check("rst_high4_reached", rises, 4);
        check("rst_pre_sck", sck, 1'b1);
        check("rst_pre_mosi", mosi, 1'b1);
        rst = 1'b1; cs = 1'b1; wr = 1'b1; addr = 8'h01; wrdat = 8'h77;
        @(negedge clk);
        #1;
        check("rst_abort_sck", sck, 1'b0);
        check("rst_abort_ncs", ncs, 1'b1);
        check("rst_abort_mosi", mosi, 1'b0);
        check("rst_abort_int", irq, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        cs = 1'b0; wr = 1'b0;
        repeat (4) @(negedge clk);
        read_reg(8'h01, d); check("rst_held_strobe_div", d, 8'h18);
        read_reg(8'h04, d); check("rst_abort_status", d, 8'h00);
        read_reg(8'h03, d); check("rst_abort_rx", d, 8'h00);
        read_reg(8'h00, d); check("rst_abort_ctrl", d, 8'h01);
        repeat (20) @(negedge clk);
        #1 check("rst_no_restart_sck", sck, 1'b0);

        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
